// File: rtl/register_univ_if.sv
// Bus bundle for register_univ: control/data towards the register, contents and flags back.
//   clr, ena, mode, d, sin : driven by the master (controller)
//   q, co, sout            : driven by the slave (register)
interface register_univ_if #(
  parameter int unsigned N = 8
);
  logic         clr;
  logic         ena;
  logic [2:0]   mode;
  logic [N-1:0] d;
  logic         sin;
  logic [N-1:0] q;
  logic         co;
  logic         sout;

  modport master (
    output clr, ena, mode, d, sin,
    input  q, co, sout
  );

  modport slave (
    input  clr, ena, mode, d, sin,
    output q, co, sout
  );
endinterface

// File: rtl/register_univ.sv
// Universal N-bit register: hold, load, shift, rotate, increment, decrement
// with a registered carry/borrow/shift-out flag.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (q = RST_VAL, co = 0)
//   bus.clr : synchronous clear, beats ena and mode
//   bus.ena : clock enable
//   bus.mode: operation select
//   bus.d   : parallel load data
//   bus.sin : serial input for shift modes
//   bus.q   : register contents (flop)
//   bus.co  : carry / borrow / shifted-out bit (flop)
//   bus.sout: bit the current mode would shift out (combinational, ignores ena)
module register_univ #(
  parameter int unsigned   N       = 8,
  parameter logic [N-1:0]  RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  register_univ_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [N-1:0] q_r;
  logic [N-1:0] q_nxt;
  logic         co_r;
  logic         co_nxt;
  logic         sout_c;

  // Next-state selection: clr, then ena, then mode.
  always_comb begin
    q_nxt  = q_r;
    co_nxt = co_r;
    if (bus.clr) begin
      q_nxt  = RST_VAL;
      co_nxt = 1'b0;
    end else if (bus.ena) begin
      case (bus.mode)
        MODE_HOLD: begin
          q_nxt  = q_r;
          co_nxt = co_r;
        end
        MODE_LOAD: begin
          q_nxt  = bus.d;
          co_nxt = 1'b0;
        end
        MODE_SHL: begin
          q_nxt  = {q_r[N-2:0], bus.sin};
          co_nxt = q_r[N-1];
        end
        MODE_SHR: begin
          q_nxt  = {bus.sin, q_r[N-1:1]};
          co_nxt = q_r[0];
        end
        MODE_ROL: begin
          q_nxt  = {q_r[N-2:0], q_r[N-1]};
          co_nxt = q_r[N-1];
        end
        MODE_ROR: begin
          q_nxt  = {q_r[0], q_r[N-1:1]};
          co_nxt = q_r[0];
        end
        // Carry out of an increment only happens from all ones.
        MODE_INC: begin
          q_nxt  = q_r + N'(1);
          co_nxt = &q_r;
        end
        // Borrow out of a decrement only happens from zero.
        MODE_DEC: begin
          q_nxt  = q_r - N'(1);
          co_nxt = ~|q_r;
        end
        default: begin
          q_nxt  = q_r;
          co_nxt = co_r;
        end
      endcase
    end
  end

  // Shift-out preview, independent of ena and clr.
  always_comb begin
    sout_c = 1'b0;
    case (bus.mode)
      MODE_SHL, MODE_ROL: sout_c = q_r[N-1];
      MODE_SHR, MODE_ROR: sout_c = q_r[0];
      default:            sout_c = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r  <= RST_VAL;
      co_r <= 1'b0;
    end else begin
      q_r  <= q_nxt;
      co_r <= co_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.co   = co_r;
  assign bus.sout = sout_c;

endmodule

// File: tb/tb_register_univ.sv
// Self-checking bench for register_univ: reset/clear, directed vector table,
// hand-written async-reset sequences and a random run against an arithmetic model.
module tb_register_univ;

  logic clk;
  logic rst;
  logic rst2;

  int n_checks;
  int n_errors;

  register_univ_if #(.N(8)) u_if ();
  register_univ_if #(.N(8)) u_if2 ();

  register_univ #(.N(8), .RST_VAL(8'h00)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  register_univ #(.N(8), .RST_VAL(8'hA5)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (u_if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ena;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic [7:0] exp_q;
    logic       exp_co;
    logic       exp_sout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic clr, input logic ena, input logic [2:0] mode,
                       input logic [7:0] d, input logic sin);
    u_if.clr  = clr;
    u_if.ena  = ena;
    u_if.mode = mode;
    u_if.d    = d;
    u_if.sin  = sin;
  endtask

  task automatic drive2(input logic clr, input logic ena, input logic [2:0] mode,
                        input logic [7:0] d);
    u_if2.clr  = clr;
    u_if2.ena  = ena;
    u_if2.mode = mode;
    u_if2.d    = d;
    u_if2.sin  = 1'b0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic clr, input logic ena, input logic [2:0] mode,
                              input logic [7:0] d, input logic sin, input logic [7:0] eq,
                              input logic eco, input logic es);
    vec_t v;
    v.clr = clr; v.ena = ena; v.mode = mode; v.d = d; v.sin = sin;
    v.exp_q = eq; v.exp_co = eco; v.exp_sout = es;
    return v;
  endfunction

  // Behavioural reference: plain integer arithmetic on the register value.
  int mq;
  int mco;

  function automatic int model_sout(input int q, input int mode);
    if (mode == 2 || mode == 4) return (q / 128) % 2;
    if (mode == 3 || mode == 5) return q % 2;
    return 0;
  endfunction

  task automatic model_step(input int clr, input int ena, input int mode,
                            input int d, input int sin);
    int nq;
    int nco;
    nq  = mq;
    nco = mco;
    if (clr != 0) begin
      nq = 0; nco = 0;
    end else if (ena != 0) begin
      case (mode)
        1: begin nq = d;                            nco = 0;              end
        2: begin nq = (mq * 2 + sin) % 256;         nco = mq / 128;       end
        3: begin nq = mq / 2 + sin * 128;           nco = mq % 2;         end
        4: begin nq = (mq * 2) % 256 + mq / 128;    nco = mq / 128;       end
        5: begin nq = mq / 2 + (mq % 2) * 128;      nco = mq % 2;         end
        6: begin nq = (mq + 1) % 256;              nco = (mq == 255) ? 1 : 0; end
        7: begin nq = (mq + 255) % 256;            nco = (mq == 0) ? 1 : 0;   end
        default: ;
      endcase
    end
    mq  = nq;
    mco = nco;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Directed vector table, applied from q = 0x00 after reset.
    vecs.push_back(mk(0, 1, 3'b001, 8'h81, 0, 8'h81, 0, 0)); // load
    vecs.push_back(mk(0, 1, 3'b010, 8'h00, 0, 8'h02, 1, 1)); // shl
    vecs.push_back(mk(0, 1, 3'b011, 8'h00, 1, 8'h81, 0, 0)); // shr sin=1
    vecs.push_back(mk(0, 0, 3'b010, 8'h33, 0, 8'h81, 0, 1)); // ena low holds
    vecs.push_back(mk(0, 1, 3'b001, 8'hFE, 0, 8'hFE, 0, 0));
    vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 8'hFF, 0, 0)); // inc
    vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 8'h00, 1, 0)); // inc wrap
    vecs.push_back(mk(0, 1, 3'b110, 8'h00, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 1, 3'b001, 8'h01, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 1, 3'b111, 8'h00, 0, 8'h00, 0, 0)); // dec
    vecs.push_back(mk(0, 1, 3'b111, 8'h00, 0, 8'hFF, 1, 0)); // dec wrap
    vecs.push_back(mk(0, 1, 3'b111, 8'h00, 0, 8'hFE, 0, 0));
    vecs.push_back(mk(1, 1, 3'b110, 8'h00, 0, 8'h00, 0, 0)); // clr beats inc
    vecs.push_back(mk(0, 1, 3'b001, 8'h81, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'h03, 1, 1)); // rol x8
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'h06, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'h0C, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'h18, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'h30, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'h60, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 8'h00, 0, 8'h81, 1, 1));
    vecs.push_back(mk(0, 1, 3'b101, 8'h00, 0, 8'hC0, 1, 1)); // ror
    vecs.push_back(mk(0, 1, 3'b000, 8'h00, 0, 8'hC0, 1, 0)); // hold keeps co
    vecs.push_back(mk(0, 0, 3'b110, 8'h00, 0, 8'hC0, 1, 0)); // ena low

    // Reset held for 5 clocks with a pending load of 0xFF.
    rst  = 1'b0;
    rst2 = 1'b0;
    drive(0, 1, 3'b001, 8'hFF, 0);
    drive2(0, 0, 3'b000, 8'h00);
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_q", int'(u_if.q), 0);
      check("rst_co", int'(u_if.co), 0);
    end
    check("rst2_q", int'(u_if2.q), 'hA5);
    drive(0, 1, 3'b000, 8'h00, 0);
    rst  = 1'b1;
    rst2 = 1'b1;
    tick();
    check("release_q", int'(u_if.q), 0);

    // Vector table.
    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ena, vecs[i].mode, vecs[i].d, vecs[i].sin);
      #1;
      check($sformatf("vec%0d_sout", i), int'(u_if.sout), int'(vecs[i].exp_sout));
      tick();
      check($sformatf("vec%0d_q", i), int'(u_if.q), int'(vecs[i].exp_q));
      check($sformatf("vec%0d_co", i), int'(u_if.co), int'(vecs[i].exp_co));
    end

    // Load sweep, then enable low holds the last value.
    for (int v = 0; v < 256; v++) begin
      drive(0, 1, 3'b001, 8'(v), 0);
      tick();
      check("sweep_q", int'(u_if.q), v);
      check("sweep_co", int'(u_if.co), 0);
    end
    drive(0, 0, 3'b001, 8'h33, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ena_hold_q", int'(u_if.q), 'hFF);
    end

    // Async reset pulse between edges while q = 0x5A.
    drive(0, 1, 3'b001, 8'h5A, 0);
    tick();
    check("pre_pulse_q", int'(u_if.q), 'h5A);
    drive(0, 0, 3'b000, 8'h00, 0);
    #2 rst = 1'b0;
    #1 check("pulse_q", int'(u_if.q), 0);
    check("pulse_co", int'(u_if.co), 0);
    #1 rst = 1'b1;
    tick();
    check("post_pulse_q", int'(u_if.q), 0);

    // Reset mid-increment at 0x10, then counting resumes from 0x00.
    drive(0, 1, 3'b001, 8'h0E, 0);
    tick();
    drive(0, 1, 3'b110, 8'h00, 0);
    tick();
    tick();
    check("inc_to_10", int'(u_if.q), 'h10);
    #2 rst = 1'b0;
    #1 check("midinc_rst_q", int'(u_if.q), 0);
    #1 rst = 1'b1;
    tick();
    check("resume_q", int'(u_if.q), 'h01);
    check("resume_co", int'(u_if.co), 0);

    // Clear to RST_VAL = 0xA5, with ena low and with ena high during increment.
    drive2(0, 1, 3'b001, 8'h3C);
    tick();
    check("dut2_load", int'(u_if2.q), 'h3C);
    drive2(1, 0, 3'b000, 8'h00);
    tick();
    check("dut2_clr_ena0", int'(u_if2.q), 'hA5);
    drive2(0, 1, 3'b001, 8'hFF);
    tick();
    drive2(1, 1, 3'b110, 8'h00);
    tick();
    check("dut2_clr_inc_q", int'(u_if2.q), 'hA5);
    check("dut2_clr_inc_co", int'(u_if2.co), 0);

    // Random run against the model, starting from a clear.
    drive(1, 0, 3'b000, 8'h00, 0);
    tick();
    mq  = 0;
    mco = 0;
    for (int i = 0; i < 2000; i++) begin
      int c, e, m, dv, s;
      c  = ($urandom_range(0, 31) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      m  = int'($urandom_range(0, 7));
      dv = int'($urandom_range(0, 255));
      s  = int'($urandom_range(0, 1));
      drive(1'(c), 1'(e), 3'(m), 8'(dv), 1'(s));
      #1;
      check("rand_sout", int'(u_if.sout), model_sout(mq, m));
      model_step(c, e, m, dv, s);
      tick();
      check("rand_q", int'(u_if.q), mq);
      check("rand_co", int'(u_if.co), mco);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_univ.md
# register_univ

Parametrised universal register, the successor of the basic enable register. It holds an N-bit word and, under an opcode, can load, shift, rotate, increment or decrement it, with a registered carry/shift-out flag. It is the common storage element for counters, serial/parallel converters and scratch registers in the sequential workshop designs.

## Interface

- N, default 8: data width in bits; legal range N >= 2.
- RST_VAL, default 0: value of q after reset and after synchronous clear; N bits wide.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, active-high.
- ena  in  1  clock enable, active-high.
- mode  in  3  operation select; see Operation.
- d  in  N  parallel load data.
- sin  in  1  serial input for the shift modes.
- q  out  N  register contents.
- co  out  1  registered carry, borrow or shift-out flag.
- sout  out  1  combinational view of the bit the current mode would shift out; 0 in non-shift modes.

## Operation

- Priority order: rst, then clr, then ena, then mode.
- rst low forces q = RST_VAL and co = 0 immediately, independent of clk.
- clr high with rst high: q <= RST_VAL and co <= 0 at the clock edge, regardless of ena and mode.
- ena low with clr low: q and co hold.
- ena high with clr low: mode selects the operation.
  - 000 hold: q and co unchanged.
  - 001 load: q <= d; co <= 0.
  - 010 shift left: q <= {q[N-2:0], sin}; co <= q[N-1].
  - 011 shift right: q <= {sin, q[N-1:1]}; co <= q[0].
  - 100 rotate left: q <= {q[N-2:0], q[N-1]}; co <= q[N-1].
  - 101 rotate right: q <= {q[0], q[N-1:1]}; co <= q[0].
  - 110 increment: q <= (q + 1) mod 2^N; co <= 1 only if the old q was all ones (wrap), otherwise 0.
  - 111 decrement: q <= (q - 1) mod 2^N; co <= 1 only if the old q was 0 (wrap), otherwise 0.
- Arithmetic is unsigned and N bits wide, so wrap-around is silent apart from co.
- sout is q[N-1] for modes 010 and 100, q[0] for modes 011 and 101, and 0 otherwise. It does not depend on ena.

## Timing

- q and co are pure flip-flop outputs with a latency of one clock edge from the inputs being sampled.
- Reset:
  - Assertion is asynchronous.
  - Release takes effect at the first rising edge with rst high.
  - Reset values: q = RST_VAL, co = 0; sout follows q.
- Reset asserted mid-operation aborts the operation at once, and no partial update survives.
- clr and ena high together: clr wins.
- Back-to-back operations are allowed on every cycle; there are no wait states.

## Test plan

With N = 8 and RST_VAL = 0x00 unless stated otherwise:

- Reset and clear:
  - Drive rst low for 5 clocks with d = 0xFF and mode = 001 -> q = 0x00, co = 0 throughout.
  - Pulse rst low between clock edges while q = 0x5A -> q = 0x00 before the next edge.
  - With RST_VAL = 0xA5, clr high -> q = 0xA5 after one edge, including when ena = 0.
- Load and enable: ena = 1, mode = 001, d sweeps 0..255 -> q equals the previous cycle's d, co = 0. Set ena = 0 with d = 0x33 -> q holds its last value for 3 cycles.
- Shift and rotate: load 0x81.
  - Shift left with sin = 0 -> q = 0x02, co = 1, sout was 1 before the edge.
  - Shift right with sin = 1 -> q = 0x81, co = 0.
  - Rotate left 8 times -> q returns to 0x81, co sequence 1,0,0,0,0,0,0,1.
- Increment wrap: load 0xFE, then increment 3 times -> q = 0xFF, 0x00, 0x01; co = 0, 1, 0.
- Decrement wrap: load 0x01, then decrement 3 times -> q = 0x00, 0xFF, 0xFE; co = 0, 1, 0.
- Priority and mid-operation reset:
  - Increment with clr = 1 -> q = RST_VAL and co = 0.
  - Assert rst low mid-increment sequence at q = 0x10 -> q = 0x00 immediately. After release, counting resumes from 0x00 on the first edge.
